// File: rtl/wave_sched_pkg.sv
// Shared types and constants for the wave voice scheduler.
// Optional build macro used by the top: WAVE_VOICE_GATE_EN (per-voice gate input).
package wave_sched_pkg;

    // Sequencer states. One voice costs ISSUE + WAIT + CAPTURE = 3 cycles.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        DONE    = 3'd4
    } state_e;

    // Read latency of the external waveform table; the WAIT state covers it.
    localparam int ROM_LATENCY = 1;

    // Right-shift applied to the voice sum so the mix cannot overflow.
    function automatic int mix_shift(input int num_voices);
        return $clog2(num_voices);
    endfunction

endpackage

// File: rtl/wave_voice_scheduler_phase_bank.sv
// Per-voice tuning words and phase accumulators.
// One write port for tuning, one indexed table-address read, one indexed phase advance.
module phase_bank #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 8,
    parameter int NUM_VOICES  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_WIDTH-1:0]        cfg_tuning,
    input  logic [$clog2(NUM_VOICES)-1:0] sel_voice,
    input  logic                          adv_en,
    output logic [ADDR_WIDTH-1:0]         sel_addr
);

    logic [PHASE_WIDTH-1:0] phase_q  [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] phase_d  [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] tuning_q [NUM_VOICES];
    logic [PHASE_WIDTH-1:0] tuning_d [NUM_VOICES];

    // Table address is the top ADDR_WIDTH bits of the selected phase.
    assign sel_addr = phase_q[sel_voice][PHASE_WIDTH-1 -: ADDR_WIDTH];

    // Next-state: tuning write and phase advance; the advance reads the old tuning.
    always_comb begin
        phase_d  = phase_q;
        tuning_d = tuning_q;
        if (cfg_we) begin
            tuning_d[cfg_voice] = cfg_tuning;
        end
        if (adv_en) begin
            phase_d[sel_voice] = phase_q[sel_voice] + tuning_q[sel_voice];
        end
    end

    // Register arrays with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i]  <= '0;
                tuning_q[i] <= '0;
            end
        end else begin
            phase_q  <= phase_d;
            tuning_q <= tuning_d;
        end
    end

endmodule

// File: rtl/wave_voice_scheduler.sv
// Wave voice scheduler: shares one registered waveform table between NUM_VOICES
// oscillators and mixes them into one sample per sample_tick.
// Build macro WAVE_VOICE_GATE_EN adds a per-voice gate input.
// Handshake: sample_tick is accepted only in IDLE; a tick while busy (including the
// DONE cycle) is dropped and flagged on overrun. sample_valid pulses one cycle with
// sample_out updated on the same edge; there is no back-pressure.
module wave_voice_scheduler
    import wave_sched_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 8,
    parameter int PHASE_WIDTH = 32,
    parameter int NUM_VOICES  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          sample_tick,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_WIDTH-1:0]        cfg_tuning,
`ifdef WAVE_VOICE_GATE_EN
    input  logic [NUM_VOICES-1:0]         gate,
`endif
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [DATA_WIDTH-1:0]         rom_dout,
    output logic [DATA_WIDTH-1:0]         sample_out,
    output logic                          sample_valid,
    output logic                          busy,
    output logic                          overrun,
    output state_e                        state_dbg
);

    localparam int VW    = $clog2(NUM_VOICES);
    localparam int SHIFT = mix_shift(NUM_VOICES);
    localparam int ACC_W = DATA_WIDTH + SHIFT;
    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);

    state_e                  state_q, state_d;
    logic [VW-1:0]           v_q, v_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [ADDR_WIDTH-1:0]   rom_addr_q, rom_addr_d;
    logic [DATA_WIDTH-1:0]   sample_out_q, sample_out_d;
    logic                    valid_q, valid_d;
    logic                    overrun_q, overrun_d;
    logic signed [ACC_W-1:0] contrib;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic                    adv_en;

    phase_bank #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .NUM_VOICES  (NUM_VOICES)
    ) u_phase_bank (
        .clk        (clk),
        .reset      (reset),
        .cfg_we     (cfg_we),
        .cfg_voice  (cfg_voice),
        .cfg_tuning (cfg_tuning),
        .sel_voice  (v_q),
        .adv_en     (adv_en),
        .sel_addr   (sel_addr)
    );

    // Sign-extended table word for the current voice, zeroed when gated off.
    always_comb begin
        contrib = {{SHIFT{rom_dout[DATA_WIDTH-1]}}, rom_dout};
`ifdef WAVE_VOICE_GATE_EN
        if (!gate[v_q]) begin
            contrib = '0;
        end
`endif
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        acc_d        = acc_q;
        rom_addr_d   = rom_addr_q;
        sample_out_d = sample_out_q;
        valid_d      = 1'b0;
        overrun_d    = sample_tick && (state_q != IDLE);
        adv_en       = 1'b0;
        case (state_q)
            IDLE: begin
                if (sample_tick) begin
                    acc_d   = '0;
                    v_d     = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                rom_addr_d = sel_addr;
                state_d    = WAIT;
            end
            WAIT: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                acc_d  = acc_q + contrib;
                adv_en = 1'b1;
                if (v_q == LAST_VOICE) begin
                    state_d = DONE;
                end else begin
                    v_d     = v_q + 1'b1;
                    state_d = ISSUE;
                end
            end
            DONE: begin
                // Top DATA_WIDTH bits of the signed sum == acc >>> SHIFT, truncated.
                sample_out_d = acc_q[SHIFT +: DATA_WIDTH];
                valid_d      = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            v_q          <= '0;
            acc_q        <= '0;
            rom_addr_q   <= '0;
            sample_out_q <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            v_q          <= v_d;
            acc_q        <= acc_d;
            rom_addr_q   <= rom_addr_d;
            sample_out_q <= sample_out_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rom_addr     = rom_addr_q;
    assign sample_out   = sample_out_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;
    assign busy         = (state_q != IDLE);
    assign state_dbg    = state_q;

endmodule
